// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with configurable width, bit order, per-bit hold
// time and idle level. Words are loaded through a valid/ready handshake. All flops update on the falling clock edge.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   DIV        = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  // Handshake: a word transfers on a falling edge where in_valid && in_ready.
  // in_ready is combinational and may rise in the final cycle of a frame, so
  // a producer holding in_valid high gets back-to-back frames with no gap.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             ser_q, ser_d;
  logic             last;
  logic             accept;

  assign last       = (state_q == ST_SHIFT) && (div_cnt_q == DIV_LAST) && (bit_cnt_q == BIT_LAST);
  assign in_ready   = (state_q == ST_IDLE) || last;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q == ST_SHIFT);
  assign bit_strobe = (state_q == ST_SHIFT) && (div_cnt_q == '0);
  assign frame_done = last;
  assign serial_out = ser_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      ser_q     <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      ser_q     <= ser_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    ser_d     = ser_q;
    if (accept) begin
      // The first bit goes out on the accepting edge itself.
      state_d   = ST_SHIFT;
      shreg_d   = data_in;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      ser_d     = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
    end else begin
      case (state_q)
        ST_IDLE: begin
          ser_d = IDLE_LEVEL;
        end
        ST_SHIFT: begin
          if (div_cnt_q != DIV_LAST) begin
            div_cnt_d = div_cnt_q + DW'(1);
          end else if (bit_cnt_q != BIT_LAST) begin
            div_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (MSB_FIRST != 0) begin
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
              ser_d   = shreg_q[WIDTH-2];
            end else begin
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
              ser_d   = shreg_q[1];
            end
          end else begin
            state_d   = ST_IDLE;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            ser_d     = IDLE_LEVEL;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ser_d   = IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a 4-bit MSB-first DIV=1 instance and an
// 8-bit LSB-first DIV=3 instance share clock and reset.
module tb_piso_serializer;

  logic       clk;
  logic       rst;

  logic [3:0] d4;
  logic       v4, r4, so4, bs4, busy4, fd4;
  logic [7:0] d8;
  logic       v8, r8, so8, bs8, busy8, fd8;

  int checks;
  int errors;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .DIV(1), .IDLE_LEVEL(1'b0)) u4 (
    .clk(clk), .rst(rst), .data_in(d4), .in_valid(v4), .in_ready(r4),
    .serial_out(so4), .bit_strobe(bs4), .busy(busy4), .frame_done(fd4)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .DIV(3), .IDLE_LEVEL(1'b0)) u8 (
    .clk(clk), .rst(rst), .data_in(d8), .in_valid(v8), .in_ready(r8),
    .serial_out(so8), .bit_strobe(bs8), .busy(busy8), .frame_done(fd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flops move on the falling edge; sample 1ns after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends w on the 8-bit instance and checks all 24 cycles of the frame.
  // A one-cycle in_valid pulse with junk data is injected at cycle pulse_at.
  task automatic frame8(input logic [7:0] w, input int pulse_at);
    int strobes;
    strobes = 0;
    d8 = w;
    v8 = 1'b1;
    check("f8_ready_before", {31'd0, r8}, 32'd1);
    tick();
    v8 = 1'b0;
    d8 = ~w;
    for (int c = 0; c < 24; c++) begin
      check("f8_serial", {31'd0, so8}, {31'd0, w[c / 3]});
      check("f8_strobe", {31'd0, bs8}, (c % 3 == 0) ? 32'd1 : 32'd0);
      check("f8_busy", {31'd0, busy8}, 32'd1);
      check("f8_done", {31'd0, fd8}, (c == 23) ? 32'd1 : 32'd0);
      check("f8_ready", {31'd0, r8}, (c == 23) ? 32'd1 : 32'd0);
      if (bs8) strobes++;
      if (c == pulse_at) begin
        v8 = 1'b1;
        d8 = 8'hFF;
      end else begin
        v8 = 1'b0;
      end
      tick();
    end
    check("f8_strobe_count", strobes, 32'd8);
    check("f8_idle_busy", {31'd0, busy8}, 32'd0);
    check("f8_idle_serial", {31'd0, so8}, 32'd0);
  endtask

  initial begin
    logic [7:0] b2b;
    logic [3:0] w4;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    d4 = '0; v4 = 1'b0;
    d8 = '0; v8 = 1'b0;

    // Reset state
    tick();
    check("rst_serial4", {31'd0, so4}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_strobe4", {31'd0, bs4}, 32'd0);
    check("rst_serial8", {31'd0, so8}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    tick();
    rst = 1'b1;

    // Idle with in_valid low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_serial4", {31'd0, so4}, 32'd0);
      check("idle_busy4", {31'd0, busy4}, 32'd0);
      check("idle_ready4", {31'd0, r4}, 32'd1);
      check("idle_done4", {31'd0, fd4}, 32'd0);
      check("idle_serial8", {31'd0, so8}, 32'd0);
      check("idle_ready8", {31'd0, r8}, 32'd1);
      check("idle_done8", {31'd0, fd8}, 32'd0);
    end

    // 4-bit MSB-first, DIV=1: 1011 -> 1,0,1,1
    w4 = 4'b1011;
    d4 = w4;
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("w4_serial", {31'd0, so4}, {31'd0, w4[3 - k]});
      check("w4_busy", {31'd0, busy4}, 32'd1);
      check("w4_strobe", {31'd0, bs4}, 32'd1);
      check("w4_done", {31'd0, fd4}, (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("w4_end_serial", {31'd0, so4}, 32'd0);
    check("w4_end_busy", {31'd0, busy4}, 32'd0);
    check("w4_end_done", {31'd0, fd4}, 32'd0);

    // Back-to-back: C then 3 with in_valid held -> 1,1,0,0,0,0,1,1
    b2b = 8'b1100_0011;
    d4 = 4'hC;
    v4 = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      if (j == 0) d4 = 4'h3;
      check("b2b_serial", {31'd0, so4}, {31'd0, b2b[7 - j]});
      check("b2b_busy", {31'd0, busy4}, 32'd1);
      check("b2b_ready", {31'd0, r4}, (j % 4 == 3) ? 32'd1 : 32'd0);
      if (j == 7) v4 = 1'b0;
      tick();
    end
    check("b2b_end_busy", {31'd0, busy4}, 32'd0);
    check("b2b_end_serial", {31'd0, so4}, 32'd0);

    // 8-bit LSB-first, DIV=3: A5 -> 1,0,1,0,0,1,0,1
    frame8(8'hA5, -1);

    // Hold-off: junk word pulsed mid-frame must be ignored
    frame8(8'h3C, 7);
    for (int i = 0; i < 4; i++) begin
      check("holdoff_no_extra", {31'd0, busy8}, 32'd0);
      tick();
    end

    // Reset mid-frame after the 2nd bit of FF
    d8 = 8'hFF;
    v8 = 1'b1;
    tick();
    v8 = 1'b0;
    repeat (6) tick();
    check("mid_pre_serial", {31'd0, so8}, 32'd1);
    check("mid_pre_busy", {31'd0, busy8}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_serial", {31'd0, so8}, 32'd0);
    check("mid_rst_busy", {31'd0, busy8}, 32'd0);
    check("mid_rst_strobe", {31'd0, bs8}, 32'd0);
    check("mid_rst_ready", {31'd0, r8}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    check("post_rst_serial", {31'd0, so8}, 32'd0);
    check("post_rst_busy", {31'd0, busy8}, 32'd0);
    frame8(8'h96, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shifter. Successor to the fixed 4-bit load/shift serializer.
- Adds configurable width, bit order, per-bit hold time (clock divider), idle line level and a valid/ready load handshake.
- Supports back-to-back frames with no idle gap.
- Sits between a word-producing datapath and a single-wire serial output.

Parameters:
- WIDTH, 8, word width in bits; legal range 2 or more.
- MSB_FIRST, 1, 1 = data_in[WIDTH-1] is sent first; 0 = data_in[0] is sent first.
- DIV, 1, clk cycles each bit is held on serial_out; legal range 1 or more.
- IDLE_LEVEL, 0, value driven on serial_out while no frame is active.

Ports:
- clk  in  1  clock; all flops update on the falling edge of clk.
- rst  in  1  reset, asynchronous, active-low.
- data_in  in  WIDTH  parallel word, sampled only on an accepting edge.
- in_valid  in  1  producer has a word on data_in.
- in_ready  out  1  block can accept a word on this edge (combinational).
- serial_out  out  1  serial data (registered).
- bit_strobe  out  1  high during the first clk cycle of every bit period.
- busy  out  1  high while a frame is being shifted.
- frame_done  out  1  high during the final clk cycle of a frame's last bit.

Behaviour:
- Reset (rst=0, any time, including mid-frame):
  - state=IDLE, shift register=0, bit_cnt=0, div_cnt=0, serial_out=IDLE_LEVEL.
  - busy=0, bit_strobe=0, frame_done=0, in_ready=1 once rst is released.
  - An aborted frame is discarded; no partial-frame output continues.
- Counter widths:
  - bit_cnt: $clog2(WIDTH) bits.
  - div_cnt: max($clog2(DIV),1) bits.
  - Both counters wrap only under FSM control, never by overflow.
- States: IDLE, SHIFT.
- Let last = (state==SHIFT) && (div_cnt==DIV-1) && (bit_cnt==WIDTH-1).
- Combinational outputs:
  - in_ready = (state==IDLE) || last.
  - busy = (state==SHIFT).
  - bit_strobe = (state==SHIFT) && (div_cnt==0).
  - frame_done = last.
- Accept = in_valid && in_ready at an active edge:
  - The shift register loads data_in.
  - serial_out takes the first bit (MSB or LSB per MSB_FIRST) at that same edge.
  - bit_cnt=0, div_cnt=0, state=SHIFT.
  - Latency: first bit appears 0 cycles after the accepting edge.
- IDLE:
  - No accept: hold state; serial_out=IDLE_LEVEL.
- SHIFT, each edge:
  - div_cnt < DIV-1: div_cnt++; serial_out held.
  - div_cnt == DIV-1 and bit_cnt < WIDTH-1: div_cnt=0, bit_cnt++; shift toward the output end; serial_out = next bit.
  - last and in_valid: back-to-back accept (rule above); no idle cycle between frames.
  - last and !in_valid: state=IDLE; serial_out=IDLE_LEVEL.
- Frame length is exactly WIDTH*DIV clk cycles. Each bit is held exactly DIV cycles.
- data_in and in_valid are ignored while in_ready=0; changes to data_in mid-frame have no effect.
- DIV=1: bit_strobe is high for every busy cycle; last coincides with bit WIDTH-1.
- Vacated shift-register positions fill with 0; they are never driven out within a frame.

Test Plan:
- Reset, then release with in_valid=0 for 5 cycles -> serial_out=IDLE_LEVEL, busy=0, in_ready=1, frame_done never high.
- WIDTH=4, MSB_FIRST=1, DIV=1, accept 4'b1011 -> serial_out 1,0,1,1 on edges 0..3; frame_done high in cycle 3 only; then IDLE_LEVEL, busy=0.
- WIDTH=8, MSB_FIRST=0, DIV=3, accept 8'hA5 -> serial_out 1,0,1,0,0,1,0,1, each held 3 cycles; bit_strobe pulses every 3rd cycle (8 pulses); busy high for exactly 24 cycles.
- Back-to-back, WIDTH=4, DIV=1:
  - in_valid held high with 4'hC then 4'h3 -> 8 contiguous bits 1,1,0,0,0,0,1,1.
  - in_ready high only on the accepting edges; busy never drops between frames.
- Hold-off: change data_in and pulse in_valid mid-frame (in_ready=0) -> current frame bits unchanged; no extra frame is sent.
- Reset mid-frame: assert rst after the 2nd bit of 8'hFF, release 2 cycles later -> serial_out=IDLE_LEVEL immediately on assertion, busy=0; a new word accepted afterwards is sent complete and correct.
